kmer_window_gen: RTL
====================

// Module: kmer_window_gen
// PURPOSE
//  Transmit side of the k-mer quality-window interface consumed by the low-quality-base scorer.
//  Accepts one read's 2-bit base qualities serially, one base per handshake.
//  Emits every sliding k-mer window as valid/quality/kmer_length, then a one-cycle done so the
//  scorer clears between reads. Sits between the read-quality fetch path and the scorer.
// PARAMETERS
//  MAX_KMER_BIT_WIDTH  6    width of kmer_length fields
//  MAX_KMER_WIDTH      64   (1<<MAX_KMER_BIT_WIDTH); window capacity in bases
//  READ_LEN_BITS       10   width of read_length / kmer_index (max read 1023 bases)
// PORTS
//  clk            in   1                      clock, all logic on posedge
//  rst            in   1                      async reset, active-high
//  start          in   1                      pulse: latch read_length/kmer_length_in, begin a read
//  read_length    in   READ_LEN_BITS          bases in this read
//  kmer_length_in in   MAX_KMER_BIT_WIDTH     k for this read
//  base_q_valid   in   1                      upstream has a base quality
//  base_q         in   2                      quality of next base (read order)
//  base_q_ready   out  1                      block accepts base_q this cycle
//  valid          out  1                      window on quality/kmer_length/kmer_index valid
//  done           out  1                      one-cycle end-of-read pulse
//  kmer_length    out  MAX_KMER_BIT_WIDTH     latched k, stable for the whole read
//  quality        out  2*MAX_KMER_WIDTH       window; base j of k-mer at bits [2j+1:2j], j=0 oldest
//  kmer_index     out  READ_LEN_BITS          read position of window base 0
//  busy           out  1                      high from accepted start until done cycle inclusive
//  cfg_error      out  1                      one-cycle pulse with done on illegal config
// BEHAVIOUR
//  Reset: state IDLE; every output 0; window reg, counters, latched config 0.
//  FSM IDLE->FILL->STREAM->FLUSH->IDLE.
//  IDLE: base_q_ready=0. start=1 latches config.
//   k==0, or k>read_length, or read_length==0: one cycle later done=1, cfg_error=1, busy=1,
//   then back to IDLE; no windows emitted.
//   Otherwise go to FILL.
//  start while not IDLE: ignored.
//  FILL/STREAM: base_q_ready=1; a base is accepted when base_q_valid&base_q_ready.
//  Window shift on accept: win <= (win>>2) | (base_q << 2*(k-1)); bits >= 2k always 0.
//  Base counter (READ_LEN_BITS) increments per accept.
//  FILL: after k-th accept, go to STREAM; window valid next cycle.
//  STREAM: each accept from k-th through read_length-th yields valid=1 exactly one cycle later,
//   quality = registered window. Latency accept->valid = 1 cycle.
//  kmer_index: 0 on first window, +1 per later window.
//  Window count = read_length-k+1. No accept cycle -> valid=0 (bubbles pass through; no backpressure
//   from downstream).
//  After read_length-th accept: base_q_ready drops next cycle, state FLUSH.
//  FLUSH: the cycle after the final valid, done=1 with valid=0; next cycle IDLE, busy=0.
//   done and valid never high together.
//  k==read_length: exactly one window, kmer_index=0.
//  Extra upstream bases after read_length are not accepted (ready=0).
//  Counters never wrap: read_length<=2^READ_LEN_BITS-1 by width.
//  rst mid-read: immediate return to IDLE, outputs 0, no done; partial read discarded.
// TESTING
//  k=4, read_length=6, q=3,0,1,2,3,0 back-to-back -> 3 valids, quality[7:0]=8'b10010011,
//   8'b11100100, 8'b00111001; kmer_index 0,1,2; done next cycle; 9 cycles start->done.
//  Same read with base_q_valid toggling 1/0 -> same 3 windows, each 1 cycle after its accept;
//   valid low on bubble cycles.
//  k=5, read_length=5 -> single window idx 0; done the cycle after; base 6 offered -> never accepted.
//  k=0; then k=7,read_length=6 -> each: done=1,cfg_error=1 one cycle after start; valid never 1.
//  Assert rst after 3 of 6 bases -> outputs 0 asynchronously; no done; fresh start runs a clean read.
//  start pulsed mid-read -> ignored, window count/indices unchanged; k=63, read_length=100 random q
//   -> 38 windows match a reference model; bits [127:126] always 0.

Source files
------------

// File: rtl/kmer_window_gen.sv
// Serial base-quality to sliding k-mer window generator; feeds the low-quality-base scorer.
// One window per accepted base once k bases are in, then a one-cycle done per read.
module kmer_window_gen #(
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_KMER_WIDTH     = 1 << MAX_KMER_BIT_WIDTH,
    parameter int READ_LEN_BITS      = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [READ_LEN_BITS-1:0]        read_length,
    input  logic [MAX_KMER_BIT_WIDTH-1:0]   kmer_length_in,
    input  logic                            base_q_valid,
    input  logic [1:0]                      base_q,
    output logic                            base_q_ready,
    output logic                            valid,
    output logic                            done,
    output logic [MAX_KMER_BIT_WIDTH-1:0]   kmer_length,
    output logic [2*MAX_KMER_WIDTH-1:0]     quality,
    output logic [READ_LEN_BITS-1:0]        kmer_index,
    output logic                            busy,
    output logic                            cfg_error
);
    localparam int QW = 2 * MAX_KMER_WIDTH;
    localparam int SW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t                        state, state_next;
    logic [READ_LEN_BITS-1:0]      len_reg;
    logic [READ_LEN_BITS-1:0]      count;
    logic [READ_LEN_BITS-1:0]      count_inc;
    logic [READ_LEN_BITS-1:0]      k_len;
    logic [READ_LEN_BITS-1:0]      k_in_len;
    logic [MAX_KMER_BIT_WIDTH-1:0] k_reg;
    logic [QW-1:0]                 win;
    logic [QW-1:0]                 win_next;
    logic [SW-1:0]                 shamt;
    logic                          accept;
    logic                          cfg_bad;

    always_comb begin
        k_in_len  = READ_LEN_BITS'(kmer_length_in);
        k_len     = READ_LEN_BITS'(k_reg);
        cfg_bad   = (kmer_length_in == '0) || (k_in_len > read_length) || (read_length == '0);
        count_inc = count + READ_LEN_BITS'(1);
        base_q_ready = (state == FILL) || (state == STREAM);
        accept    = base_q_valid && base_q_ready;
        // newest base lands at slot k-1; right shift keeps everything above 2k-1 clear
        shamt     = SW'(k_reg - 1'b1) << 1;
        win_next  = (win >> 2) | (QW'(base_q) << shamt);
        quality     = win;
        kmer_length = k_reg;
        busy        = (state != IDLE) || done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start && !cfg_bad) state_next = FILL;
            FILL:   if (accept) begin
                        if (count_inc == len_reg)    state_next = FLUSH;
                        else if (count_inc == k_len) state_next = STREAM;
                    end
            STREAM: if (accept && count_inc == len_reg) state_next = FLUSH;
            FLUSH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg      <= '0;
            len_reg    <= '0;
            count      <= '0;
            win        <= '0;
            valid      <= 1'b0;
            done       <= 1'b0;
            cfg_error  <= 1'b0;
            kmer_index <= '0;
        end else begin
            valid     <= 1'b0;
            done      <= 1'b0;
            cfg_error <= 1'b0;
            if (state == IDLE && start) begin
                k_reg      <= kmer_length_in;
                len_reg    <= read_length;
                count      <= '0;
                win        <= '0;
                kmer_index <= '0;
                if (cfg_bad) begin
                    done      <= 1'b1;
                    cfg_error <= 1'b1;
                end
            end
            if (accept) begin
                win   <= win_next;
                count <= count_inc;
                if (count_inc >= k_len) begin
                    valid      <= 1'b1;
                    kmer_index <= count_inc - k_len;
                end
            end
            if (state == FLUSH) done <= 1'b1;
        end
    end
endmodule
